// File: rtl/multiplier_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Define MULTIPLIER_ITER_SIGNED_EN to honour sgn (two's-complement operands); otherwise sgn is ignored.
module multiplier_iter #(
  parameter int WIDTH     = 5,
  parameter int ZERO_SKIP = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  output logic               rdy,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               done,
  output logic [2*WIDTH-1:0] ab,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] ab_q, ab_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               zero_hit;

`ifdef MULTIPLIER_ITER_SIGNED_EN
  logic neg_q, neg_d;
  logic neg_in;

  // The core always multiplies magnitudes; the sign is reapplied on entry to DONE.
  always_comb begin
    mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b  = (sgn && b[WIDTH-1]) ? -b : b;
    neg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign mag_a      = a;
  assign mag_b      = b;
`endif

  assign zero_hit = (ZERO_SKIP != 0) && ((a == '0) || (b == '0));
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ab_q     <= '0;
`ifdef MULTIPLIER_ITER_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ab_q     <= ab_d;
`ifdef MULTIPLIER_ITER_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = zero_hit ? DONE : CALC;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ab_d     = ab_q;
`ifdef MULTIPLIER_ITER_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MULTIPLIER_ITER_SIGNED_EN
          neg_d    = neg_in;
`endif
          if (zero_hit) ab_d = '0;
        end
      end
      CALC: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
`ifdef MULTIPLIER_ITER_SIGNED_EN
          ab_d = neg_q ? -acc_step : acc_step;
`else
          ab_d = acc_step;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rdy  = (state_q == IDLE);
    busy = (state_q == CALC);
    done = (state_q == DONE);
    ab   = ab_q;
  end

endmodule

// File: tb/tb_multiplier_iter.sv
// Directed bench for multiplier_iter (WIDTH=5): one instance with ZERO_SKIP=0, one with ZERO_SKIP=1.
// Signed vectors are selected when MULTIPLIER_ITER_SIGNED_EN is defined.
module tb_multiplier_iter;

  localparam int W = 5;

  typedef struct packed {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] p;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0;
  logic           req_z = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           sgn = 1'b0;
  logic           rdy, done, busy;
  logic           rdy_z, done_z, busy_z;
  logic [2*W-1:0] ab, ab_z;

  int checks = 0;
  int errors = 0;

  multiplier_iter #(.WIDTH(W), .ZERO_SKIP(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rdy(rdy), .a(a), .b(b),
    .sgn(sgn), .done(done), .ab(ab), .busy(busy)
  );

  multiplier_iter #(.WIDTH(W), .ZERO_SKIP(1)) dut_zs (
    .clk(clk), .rst_n(rst_n), .req(req_z), .rdy(rdy_z), .a(a), .b(b),
    .sgn(sgn), .done(done_z), .ab(ab_z), .busy(busy_z)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one request and reports edges from acceptance to the first done (-1 if none),
  // the product seen with that done, and the number of done cycles including the one after.
  task automatic do_op(input logic zs, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input logic scramble,
                       output int lat, output logic [2*W-1:0] res, output int ndone);
    lat   = -1;
    res   = '0;
    ndone = 0;
    a = av; b = bv; sgn = sv;
    if (zs) req_z = 1'b1; else req = 1'b1;
    tick;
    if (!scramble) begin req = 1'b0; req_z = 1'b0; end
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin
        if (scramble) begin a = W'($urandom); b = W'($urandom); end
        tick;
      end
      if ((zs ? done_z : done) === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = i; res = zs ? ab_z : ab; end
      end
      if (lat >= 0) break;
    end
    req = 1'b0; req_z = 1'b0;
    tick;
    if ((zs ? done_z : done) === 1'b1) ndone++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 1'b1; req_z = 1'b1; a = 5'd31; b = 5'd31;
    tick; tick;
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy: got %b expected 1", rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (ab !== 10'd0) begin errors++; $display("[TB] FAIL reset_ab: got %0d expected 0", ab); end
    checks++; if (rdy_z !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy_zs: got %b expected 1", rdy_z); end
    req = 1'b0; req_z = 1'b0; rst_n = 1'b1;
    tick;
  endtask

  task automatic test_unsigned;
    int lat, nd;
    logic [2*W-1:0] res;
    vec_t vecs[$];
    do_op(1'b0, 5'd31, 5'd31, 1'b0, 1'b0, lat, res, nd);
    checks++; if (lat !== W) begin errors++; $display("[TB] FAIL u31x31_latency: got %0d expected %0d", lat, W); end
    checks++; if (res !== 10'h3C1) begin errors++; $display("[TB] FAIL u31x31_ab: got %0d expected 961", res); end
    checks++; if (nd !== 1) begin errors++; $display("[TB] FAIL u31x31_done_count: got %0d expected 1", nd); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL u31x31_rdy_after: got %b expected 1", rdy); end
    vecs.push_back('{1'b0, 5'd13, 5'd11, 10'd143});
    vecs.push_back('{1'b0, 5'd1,  5'd31, 10'd31});
    vecs.push_back('{1'b0, 5'd16, 5'd16, 10'd256});
    vecs.push_back('{1'b0, 5'd30, 5'd2,  10'd60});
    foreach (vecs[k]) begin
      do_op(1'b0, vecs[k].a, vecs[k].b, vecs[k].s, 1'b0, lat, res, nd);
      checks++;
      if (res !== vecs[k].p || lat !== W) begin
        errors++;
        $display("[TB] FAIL unsigned_vec%0d: got ab=%0d lat=%0d expected ab=%0d lat=%0d", k, res, lat, vecs[k].p, W);
      end
    end
  endtask

  task automatic test_signed;
    int lat, nd;
    logic [2*W-1:0] res;
    vec_t vecs[$];
`ifdef MULTIPLIER_ITER_SIGNED_EN
    vecs.push_back('{1'b1, 5'h10, 5'd15, 10'h310});
    vecs.push_back('{1'b1, 5'h10, 5'h10, 10'h100});
    vecs.push_back('{1'b1, 5'h1D, 5'd3,  10'h3F7});
    vecs.push_back('{1'b1, 5'd3,  5'h1B, 10'h3F1});
    vecs.push_back('{1'b0, 5'h10, 5'd15, 10'h0F0});
`else
    vecs.push_back('{1'b1, 5'h10, 5'd15, 10'd240});
    vecs.push_back('{1'b1, 5'h1D, 5'd3,  10'd87});
    vecs.push_back('{1'b1, 5'h10, 5'h10, 10'd256});
`endif
    foreach (vecs[k]) begin
      do_op(1'b0, vecs[k].a, vecs[k].b, vecs[k].s, 1'b0, lat, res, nd);
      checks++;
      if (res !== vecs[k].p || lat !== W) begin
        errors++;
        $display("[TB] FAIL sgn_vec%0d: got ab=%0h lat=%0d expected ab=%0h lat=%0d", k, res, lat, vecs[k].p, W);
      end
    end
  endtask

  task automatic test_zero_skip;
    int lat, nd;
    logic [2*W-1:0] res;
    do_op(1'b1, 5'd6, 5'd7, 1'b0, 1'b0, lat, res, nd);
    checks++; if (res !== 10'd42 || lat !== W) begin errors++; $display("[TB] FAIL zs_6x7: got ab=%0d lat=%0d expected ab=42 lat=%0d", res, lat, W); end
    do_op(1'b1, 5'd0, 5'd7, 1'b0, 1'b0, lat, res, nd);
    checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL zs_0x7_latency: got %0d expected 0", lat); end
    checks++; if (res !== 10'd0) begin errors++; $display("[TB] FAIL zs_0x7_ab: got %0d expected 0", res); end
    checks++; if (nd !== 1) begin errors++; $display("[TB] FAIL zs_0x7_done_count: got %0d expected 1", nd); end
    do_op(1'b1, 5'd9, 5'd8, 1'b0, 1'b0, lat, res, nd);
    do_op(1'b1, 5'd9, 5'd0, 1'b0, 1'b0, lat, res, nd);
    checks++; if (res !== 10'd0 || lat !== 0) begin errors++; $display("[TB] FAIL zs_9x0: got ab=%0d lat=%0d expected ab=0 lat=0", res, lat); end
    do_op(1'b0, 5'd0, 5'd7, 1'b0, 1'b0, lat, res, nd);
    checks++; if (lat !== W) begin errors++; $display("[TB] FAIL nozs_0x7_latency: got %0d expected %0d", lat, W); end
    checks++; if (res !== 10'd0) begin errors++; $display("[TB] FAIL nozs_0x7_ab: got %0d expected 0", res); end
  endtask

  task automatic test_req_hold;
    int lat, nd;
    logic [2*W-1:0] res;
    do_op(1'b0, 5'd21, 5'd27, 1'b0, 1'b1, lat, res, nd);
    checks++; if (res !== 10'd567) begin errors++; $display("[TB] FAIL hold_ab: got %0d expected 567", res); end
    checks++; if (nd !== 1) begin errors++; $display("[TB] FAIL hold_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_reset_abort;
    int lat, nd;
    logic [2*W-1:0] res;
    a = 5'd6; b = 5'd5; sgn = 1'b0; req = 1'b1;
    tick;
    req = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    tick;
    checks++; if (rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_flags: got rdy=%b busy=%b done=%b expected 1 0 0", rdy, busy, done); end
    checks++; if (ab !== 10'd0) begin errors++; $display("[TB] FAIL abort_ab: got %0d expected 0", ab); end
    rst_n = 1'b1; req = 1'b1; a = 5'd3; b = 5'd4;
    tick;
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_reaccept: got busy=%b expected 1", busy); end
    lat = -1; res = '0; nd = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (done === 1'b1) begin
        nd++;
        if (lat < 0) begin lat = i; res = ab; end
      end
    end
    checks++; if (lat !== W || res !== 10'd12) begin errors++; $display("[TB] FAIL abort_next_op: got ab=%0d lat=%0d expected ab=12 lat=%0d", res, lat, W); end
    checks++; if (nd !== 1) begin errors++; $display("[TB] FAIL abort_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    logic [2*W-1:0] r1, r2;
    t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    a = 5'd7; b = 5'd9; sgn = 1'b0; req = 1'b1;
    tick;
    a = 5'd31; b = 5'd1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (done === 1'b1) begin
        if (t1 < 0) begin t1 = i; r1 = ab; end
        else begin t2 = i; r2 = ab; end
      end
      if (t2 >= 0) break;
    end
    req = 1'b0;
    tick;
    checks++; if (t1 !== W || r1 !== 10'd63) begin errors++; $display("[TB] FAIL b2b_first: got ab=%0d at %0d expected ab=63 at %0d", r1, t1, W); end
    checks++; if ((t2 - t1) !== W + 2) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", t2 - t1, W + 2); end
    checks++; if (r2 !== 10'd31) begin errors++; $display("[TB] FAIL b2b_second_ab: got %0d expected 31", r2); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_zero_skip;
    test_req_hold;
    test_reset_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_iter.md
MULTIPLIER_ITER -- requirements
Module: multiplier_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter ZERO_SKIP, default 0, meaning 1 enables one-cycle completion when either operand is zero.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req  input  1  request; a, b and sgn are valid when req=1.
REQ-006 SHALL have port rdy  output  1  block can accept a request this cycle.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a and b.
REQ-010 SHALL have port done  output  1  one-cycle pulse; ab is valid.
REQ-011 SHALL have port ab  output  2*WIDTH  product.
REQ-012 SHALL have port busy  output  1  multiplication in progress (state CALC).

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE, with rdy=1 only in IDLE and busy=1 only in CALC.
REQ-014 SHALL accept a request on a rising edge where req=1 and rdy=1, capturing a, b and sgn into internal registers and entering CALC.
REQ-015 SHALL ignore req whenever rdy=0, so input changes during CALC or DONE have no effect.
REQ-016 SHALL perform shift-add processing of one multiplier bit per cycle in CALC, for exactly WIDTH cycles.
REQ-017 SHALL, with acceptance at edge E0, leave CALC at edge E(WIDTH), enter DONE there, and drive done=1 for the cycle following E(WIDTH) only.
REQ-018 SHALL return from DONE to IDLE unconditionally on the next edge, so a new request is accepted no earlier than edge E(WIDTH+2).
REQ-019 SHALL update ab only on entry to DONE, and hold ab stable from then until the next entry to DONE.
REQ-020 SHALL, with ZERO_SKIP=1 and a captured operand of 0, go directly from IDLE to DONE at E0, with ab=0 and done=1 in the cycle after E0.
REQ-021 SHALL, with ZERO_SKIP=0, always use the full WIDTH-cycle latency, including zero operands.
REQ-022 SHALL, when sgn=0 (or when signed support is compiled out), produce ab equal to the exact unsigned product, which never overflows 2*WIDTH bits.
REQ-023 SHALL, when sgn=1 with signed support, produce ab equal to the exact two's-complement product in 2*WIDTH bits, including (-2^(WIDTH-1))*(-2^(WIDTH-1)).
REQ-024 SHALL hold done=0 in IDLE and CALC, and SHALL never pulse done twice for one request.

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, enter IDLE and set rdy=1, busy=0, done=0, ab=0 and clear all internal operand and accumulator registers.
REQ-026 SHALL, on reset during CALC or DONE, abort the operation, produce no done pulse for it, and accept a new request on the first edge after rst_n returns to 1.
REQ-027 SHALL give reset priority over a simultaneous req.

Configuration
REQ-028 SHALL, with macro MULTIPLIER_ITER_SIGNED_EN defined, honour sgn as specified in REQ-023, using magnitude conversion at capture and conditional negation on entry to DONE, with unchanged latency.
REQ-029 SHALL, without MULTIPLIER_ITER_SIGNED_EN, keep the sgn port but ignore it, treat all operands as unsigned, and synthesise no signed logic.

Verification
REQ-030 SHALL cover: WIDTH=5, sgn=0, a=31, b=31, single req -> done pulses exactly 6 cycles after the acceptance edge's cycle, ab=961 (0x3C1), rdy=1 the following cycle.
REQ-031 SHALL cover: signed build, WIDTH=5, sgn=1, a=-16 (0x10), b=15 -> ab=0x310 (-240); a=-16, b=-16 -> ab=0x100 (256).
REQ-032 SHALL cover: ZERO_SKIP=1, a=0, b=7 -> done in the cycle after acceptance, ab=0; with ZERO_SKIP=0 the same stimulus -> done after WIDTH+1 cycles, ab=0.
REQ-033 SHALL cover: req held high with a and b changing every cycle during CALC -> result equals the product of the operands captured at acceptance, and exactly one done per accepted request.
REQ-034 SHALL cover: rst_n=0 asserted for one cycle at CALC cycle 3 of 6x5 -> no done, ab=0, rdy=1; the next req with a=3, b=4 -> ab=12.
REQ-035 SHALL cover: back-to-back requests 7x9 then 31x1 with req held high -> two done pulses separated by WIDTH+2 cycles, ab=63 then ab=31.
